// File: rtl/sar_cmp_search_pkg.sv
// Shared types and helpers for the successive-approximation comparator search.
// Holds the FSM state encoding, the default operand width and the flag sanity check.
package sar_cmp_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Exactly one of EQ/GT/LT must be set for a trial to be trusted.
  function automatic logic flags_onehot(input logic eq, input logic gt, input logic lt);
    logic ok;
    case ({eq, gt, lt})
      3'b100, 3'b010, 3'b001: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/sar_cmp_search_if.sv
// Initiator/comparator link: trial value out, EQ/GT/LT back, plus start and result status.
// master = search engine side, slave = comparator/requester side.
interface sar_cmp_search_if
  import sar_cmp_search_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             EQ;
  logic             GT;
  logic             LT;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;
  logic             err;

  modport master (
    input  start, EQ, GT, LT,
    output guess, busy, done, result, found, err
  );

  modport slave (
    output start, EQ, GT, LT,
    input  guess, busy, done, result, found, err
  );
endinterface

// File: rtl/Bit4_MC.sv
// 4-bit magnitude comparator: purely combinational EQ/GT/LT of a against b.
// Zero latency, no backpressure.
module Bit4_MC (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       EQ,
  output logic       GT,
  output logic       LT
);
  assign EQ = (a == b);
  assign GT = (a > b);
  assign LT = (a < b);
endmodule

// File: rtl/sar_cmp_search.sv
// Recovers the comparator's hidden operand MSB-first, one trial per cycle, exiting early on EQ.
// Latency 1..WIDTH trials then a one-cycle done pulse; start is ignored while busy.
module sar_cmp_search
  import sar_cmp_search_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
)(
  input  logic clk,
  input  logic rst_n,
  sar_cmp_search_if.master bus
);
  localparam int               KW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] acc_q, acc_d, acc_nxt;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      guess_q  <= '0;
      acc_q    <= '0;
      result_q <= '0;
      k_q      <= KW'(WIDTH - 1);
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      k_q      <= k_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    acc_d    = acc_q;
    result_d = result_q;
    k_d      = k_q;
    found_d  = found_q;
    err_d    = err_q;
    // A GT answer means the trial bit belongs in the result.
    acc_nxt  = bus.GT ? guess_q : acc_q;

    unique case (state_q)
      IDLE: begin
        guess_d = '0;
        if (bus.start) begin
          acc_d   = '0;
          k_d     = KW'(WIDTH - 1);
          guess_d = ONE << (WIDTH - 1);
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = TRIAL;
        end
      end
      TRIAL: begin
        if (!flags_onehot(bus.EQ, bus.GT, bus.LT)) begin
          err_d    = 1'b1;
          result_d = acc_q;
          guess_d  = '0;
          state_d  = DONE;
        end else if (bus.EQ) begin
          result_d = guess_q;
          found_d  = 1'b1;
          guess_d  = '0;
          state_d  = DONE;
        end else begin
          acc_d = acc_nxt;
          if (k_q == '0) begin
            result_d = acc_nxt;
            found_d  = 1'b0;
            guess_d  = '0;
            state_d  = DONE;
          end else begin
            k_d     = k_q - KW'(1);
            guess_d = acc_nxt | (ONE << k_d);
          end
        end
      end
      DONE: begin
        guess_d = '0;
        state_d = IDLE;
      end
      default: begin
        guess_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.found  = found_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_cmp_search.sv
// Bench for sar_cmp_search: directed vector table, reset and back-to-back corner cases,
// and randomized searches checked against a plain-arithmetic successive-approximation model.
module tb_sar_cmp_search;
  import sar_cmp_search_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] a_reg;
  logic       frc;
  logic       mc_eq, mc_gt, mc_lt;

  int n_tests;
  int n_fail;

  logic [3:0] obs_g[$];
  int         obs_done_cyc;
  logic [3:0] obs_res;
  logic       obs_found;
  logic       obs_err;
  logic       obs_to;

  sar_cmp_search_if #(.WIDTH(4)) sif ();

  sar_cmp_search #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif.master)
  );

  Bit4_MC u_mc (
    .a  (a_reg),
    .b  (sif.guess),
    .EQ (mc_eq),
    .GT (mc_gt),
    .LT (mc_lt)
  );

  // Fault injection: EQ and GT both asserted while frc is high.
  assign sif.EQ = frc ? 1'b1 : mc_eq;
  assign sif.GT = frc ? 1'b1 : mc_gt;
  assign sif.LT = frc ? 1'b0 : mc_lt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      a;
    int              ft;
    int              ms;
    logic [0:3][3:0] g;
    int              n;
    logic [3:0]      r;
    logic            f;
    logic            e;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: build the answer bit by bit, keeping a trial bit when a >= trial.
  task automatic model(input logic [3:0] a, output logic [0:3][3:0] g, output int n,
                       output logic [3:0] r, output logic f);
    logic [3:0] cand;
    logic       hit;
    r = 4'd0; n = 0; f = 1'b0; g = '0; hit = 1'b0;
    for (int b = 3; b >= 0; b--) begin
      if (!hit) begin
        cand = r | (4'd1 << b);
        g[n] = cand;
        n++;
        if (cand == a) begin
          r   = a;
          f   = 1'b1;
          hit = 1'b1;
        end else if (cand < a) begin
          r = cand;
        end
      end
    end
  endtask

  // Called on the negedge of the first trial cycle; returns on the negedge where done is high.
  task automatic run_trials(input int ft, input int ms);
    int cyc;
    obs_g  = {};
    obs_to = 1'b0;
    cyc    = 1;
    while (sif.done !== 1'b1) begin
      if (cyc > 20) begin
        obs_to = 1'b1;
        break;
      end
      if (sif.busy === 1'b1) obs_g.push_back(sif.guess);
      frc = (cyc == ft);
      if (ms != 0) sif.start = (cyc == ms);
      @(negedge clk);
      cyc++;
    end
    frc = 1'b0;
    if (ms != 0) sif.start = 1'b0;
    obs_done_cyc = cyc;
    obs_res      = sif.result;
    obs_found    = sif.found;
    obs_err      = sif.err;
  endtask

  task automatic check_obs(input string tag, input logic [0:3][3:0] eg, input int en,
                           input logic [3:0] er, input logic ef, input logic ee);
    check({tag, " timeout"}, 32'(obs_to), 32'd0);
    check({tag, " trials"}, 32'(obs_g.size()), 32'(en));
    for (int i = 0; i < en; i++)
      check($sformatf("%s guess%0d", tag, i),
            (i < obs_g.size()) ? 32'(obs_g[i]) : 32'hxxxxxxxx, 32'(eg[i]));
    check({tag, " done_cycle"}, 32'(obs_done_cyc), 32'(en + 1));
    check({tag, " result"}, 32'(obs_res), 32'(er));
    check({tag, " found"}, 32'(obs_found), 32'(ef));
    check({tag, " err"}, 32'(obs_err), 32'(ee));
  endtask

  task automatic search(input logic [3:0] av, input int ft, input int ms);
    @(negedge clk);
    a_reg     = av;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    run_trials(ft, ms);
  endtask

  task automatic post_done(input string tag);
    @(negedge clk);
    check({tag, " done_drop"}, 32'(sif.done), 32'd0);
    check({tag, " busy_drop"}, 32'(sif.busy), 32'd0);
  endtask

  initial begin
    logic [0:3][3:0] eg;
    int              en;
    logic [3:0]      er;
    logic            ef;
    logic            seen_done;

    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    a_reg     = 4'd0;
    frc       = 1'b0;
    sif.start = 1'b0;

    vt[0] = '{4'b0110, 0, 0, {4'h8, 4'h4, 4'h6, 4'h0}, 3, 4'h6, 1'b1, 1'b0};
    vt[1] = '{4'b0000, 0, 0, {4'h8, 4'h4, 4'h2, 4'h1}, 4, 4'h0, 1'b0, 1'b0};
    vt[2] = '{4'b1101, 0, 2, {4'h8, 4'hC, 4'hE, 4'hD}, 4, 4'hD, 1'b1, 1'b0};
    vt[3] = '{4'b1010, 2, 0, {4'h8, 4'hC, 4'h0, 4'h0}, 2, 4'h8, 1'b0, 1'b1};

    #1;
    check("reset guess", 32'(sif.guess), 32'd0);
    check("reset busy", 32'(sif.busy), 32'd0);
    check("reset done", 32'(sif.done), 32'd0);
    check("reset result", 32'(sif.result), 32'd0);
    check("reset found", 32'(sif.found), 32'd0);
    check("reset err", 32'(sif.err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      search(vt[i].a, vt[i].ft, vt[i].ms);
      check_obs($sformatf("vec%0d", i), vt[i].g, vt[i].n, vt[i].r, vt[i].f, vt[i].e);
      post_done($sformatf("vec%0d", i));
    end

    // Reset during the third trial of a=1111.
    @(negedge clk);
    a_reg     = 4'hF;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(negedge clk);
    check("rst pre guess", 32'(sif.guess), 32'hE);
    rst_n = 1'b0;
    #1;
    check("rst guess", 32'(sif.guess), 32'd0);
    check("rst busy", 32'(sif.busy), 32'd0);
    check("rst result", 32'(sif.result), 32'd0);
    seen_done = sif.done;
    repeat (3) begin
      @(negedge clk);
      seen_done = seen_done | sif.done;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen_done = seen_done | sif.done;
    end
    check("rst no_done", 32'(seen_done), 32'd0);
    model(4'hF, eg, en, er, ef);
    search(4'hF, 0, 0);
    check_obs("after_rst", eg, en, er, ef, 1'b0);
    post_done("after_rst");

    // Exhaustive sweep with start held high.
    @(negedge clk);
    sif.start = 1'b1;
    for (int a = 0; a < 16; a++) begin
      a_reg = 4'(a);
      @(negedge clk);
      model(4'(a), eg, en, er, ef);
      run_trials(0, 0);
      check_obs($sformatf("sweep%0d", a), eg, en, er, ef, 1'b0);
      check($sformatf("sweep%0d result_eq_a", a), 32'(obs_res), 32'(a));
      @(negedge clk);
      check($sformatf("sweep%0d idle", a), 32'(sif.busy), 32'd0);
    end
    sif.start = 1'b0;

    // Randomized searches with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      logic [3:0] ra;
      ra = 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      model(ra, eg, en, er, ef);
      search(ra, 0, 0);
      check_obs($sformatf("rand%0d a=%0h", i, ra), eg, en, er, ef, 1'b0);
      post_done($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
